// File: rtl/bus_master_arb_pkg.sv
// bus_master_arb_pkg: shared word/pointer types and Avalon response codes for the bus master.
//   word_t    : 32-bit data word
//   ptr_t     : 30-bit word address
//   AVL_OKAY  : Avalon "no error" response
//   byte_addr : word address to Avalon byte address
package bus_master_arb_pkg;
    typedef logic [31:0] word_t;
    typedef logic [29:0] ptr_t;
    localparam logic [1:0] AVL_OKAY = 2'b00;
    function automatic word_t byte_addr(input ptr_t a);
        return {a, 2'b00};
    endfunction
endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: combinational round-robin pick among pending ports.
//   pend_i  : pending request mask
//   ptr_i   : highest-priority index (pointer register lives in the parent)
//   mask_i  : ports currently allowed (lock owner only, or all ones)
//   grant_o : one-hot grant
//   valid_o : a grant was made
module bus_rr_arbiter #(
    parameter int PORTS = 2,
    localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] pend_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic [PORTS-1:0] mask_i,
    output logic [PORTS-1:0] grant_o,
    output logic             valid_o
);
    logic [PORTS-1:0] req;
    logic [PW:0]      idx;
    always_comb begin
        req = pend_i & mask_i;
        grant_o = '0;
        idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            // scan from the pointer, wrapping modulo PORTS (one extra bit avoids overflow)
            idx = {1'b0, ptr_i} + (PW+1)'(i);
            idx = idx >= (PW+1)'(PORTS) ? idx - (PW+1)'(PORTS) : idx;
            if (grant_o == '0 && req[idx[PW-1:0]])
                grant_o[idx[PW-1:0]] = 1'b1;
        end
    end
    assign valid_o = |grant_o;
endmodule

// File: rtl/bus_master_arb.sv
// bus_master_arb: multi-port round-robin Avalon-MM bus master with exclusive-lock hold.
//   clk, rst                     : clock, asynchronous active-high reset
//   port_start_i/write/addr/...  : per-port request capture (sampled with start)
//   port_ex_lock_i               : per-port exclusive-sequence level
//   port_ready_o/ex_fail_o       : per-port completion pulse and exclusive failure
//   port_data_rd_o               : shared read data, valid with any ready
//   avl_*                        : Avalon-MM master
// Optional feature: CONFIG_BUS_MASTER_TIMEOUT_EN aborts a command after TIMEOUT waitrequest cycles.
module bus_master_arb
    import bus_master_arb_pkg::*;
#(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       port_start_i,
    input  logic [PORTS-1:0]       port_write_i,
    input  ptr_t [PORTS-1:0]       port_addr_i,
    input  word_t [PORTS-1:0]      port_data_wr_i,
    input  logic [PORTS-1:0][3:0]  port_data_be_i,
    input  logic [PORTS-1:0]       port_ex_lock_i,
    output logic [PORTS-1:0]       port_ready_o,
    output word_t                  port_data_rd_o,
    output logic [PORTS-1:0]       port_ex_fail_o,
    output word_t                  avl_address_o,
    output logic                   avl_read_o,
    output logic                   avl_write_o,
    output logic                   avl_lock_o,
    output word_t                  avl_writedata_o,
    output logic [3:0]             avl_byteenable_o,
    input  word_t                  avl_readdata_i,
    input  logic                   avl_waitrequest_i,
    input  logic [1:0]             avl_response_i
);
    localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;
    if (PORTS < 1 || PORTS > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("bus_master_arb: PORTS must be 1..8 and TIMEOUT >= 1");
    end
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
    state_e                 state_q;
    logic [PORTS-1:0]       pend_q, wr_q;
    ptr_t [PORTS-1:0]       addr_q;
    word_t [PORTS-1:0]      data_q;
    logic [PORTS-1:0][3:0]  be_q;
    logic [PW-1:0]          g_q, ptr_q, owner_q, gidx;
    logic [PORTS-1:0]       accept, req, mask, grant;
    logic                   gvalid, lock_eff, g_wr;
    ptr_t                   g_addr;
    word_t                  g_data;
    logic [3:0]             g_be;
`ifdef CONFIG_BUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]          to_q;
`endif
    always_comb begin
        // avl_lock_o doubles as the lock-held flag; it drops once the owner lowers ex_lock
        lock_eff = avl_lock_o & port_ex_lock_i[owner_q];
        mask = lock_eff ? PORTS'(1) << owner_q : '1;
        accept = '0;
        for (int p = 0; p < PORTS; p++)
            accept[p] = port_start_i[p] & ~pend_q[p] & ~(state_q == S_ACCESS && g_q == PW'(p));
        // same-cycle starts join arbitration so a start can issue on the next edge
        req = pend_q | accept;
        gidx = '0;
        for (int i = 0; i < PORTS; i++)
            if (grant[i]) gidx = PW'(i);
        g_wr   = accept[gidx] ? port_write_i[gidx]   : wr_q[gidx];
        g_addr = accept[gidx] ? port_addr_i[gidx]    : addr_q[gidx];
        g_data = accept[gidx] ? port_data_wr_i[gidx] : data_q[gidx];
        g_be   = accept[gidx] ? port_data_be_i[gidx] : be_q[gidx];
    end
    bus_rr_arbiter #(.PORTS(PORTS)) u_arb (
        .pend_i  (req),
        .ptr_i   (ptr_q),
        .mask_i  (mask),
        .grant_o (grant),
        .valid_o (gvalid)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pend_q           <= '0;
            wr_q             <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            be_q             <= '0;
            g_q              <= '0;
            ptr_q            <= '0;
            owner_q          <= '0;
            port_ready_o     <= '0;
            port_ex_fail_o   <= '0;
            port_data_rd_o   <= '0;
            avl_address_o    <= '0;
            avl_read_o       <= 1'b0;
            avl_write_o      <= 1'b0;
            avl_lock_o       <= 1'b0;
            avl_writedata_o  <= '0;
            avl_byteenable_o <= '0;
`ifdef CONFIG_BUS_MASTER_TIMEOUT_EN
            to_q             <= '0;
`endif
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (accept[p]) begin
                    pend_q[p] <= 1'b1;
                    wr_q[p]   <= port_write_i[p];
                    addr_q[p] <= port_addr_i[p];
                    data_q[p] <= port_data_wr_i[p];
                    be_q[p]   <= port_data_be_i[p];
                end
            end
            case (state_q)
                S_IDLE, S_RESP: begin
                    port_ready_o   <= '0;
                    port_ex_fail_o <= '0;
                    avl_lock_o     <= lock_eff;
                    state_q        <= gvalid ? S_ACCESS : S_IDLE;
                    if (gvalid) begin
                        g_q              <= gidx;
                        owner_q          <= gidx;
                        ptr_q            <= gidx == PW'(PORTS - 1) ? '0 : gidx + 1'b1;
                        pend_q[gidx]     <= 1'b0;
                        avl_read_o       <= ~g_wr;
                        avl_write_o      <= g_wr;
                        avl_address_o    <= byte_addr(g_addr);
                        avl_writedata_o  <= g_data;
                        avl_byteenable_o <= g_be;
                        // granting an owner with ex_lock low is what releases the lock
                        avl_lock_o       <= port_ex_lock_i[gidx];
`ifdef CONFIG_BUS_MASTER_TIMEOUT_EN
                        to_q             <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (!avl_waitrequest_i) begin
                        state_q        <= S_RESP;
                        avl_read_o     <= 1'b0;
                        avl_write_o    <= 1'b0;
                        port_ready_o   <= PORTS'(1) << g_q;
                        port_data_rd_o <= avl_readdata_i;
                        // avl_lock_o equals the granted port's ex_lock for the whole access
                        port_ex_fail_o <= (avl_lock_o && avl_response_i != AVL_OKAY) ? PORTS'(1) << g_q : '0;
                    end
`ifdef CONFIG_BUS_MASTER_TIMEOUT_EN
                    else if (to_q == TW'(TIMEOUT - 1)) begin
                        state_q        <= S_RESP;
                        avl_read_o     <= 1'b0;
                        avl_write_o    <= 1'b0;
                        avl_lock_o     <= 1'b0;
                        port_ready_o   <= PORTS'(1) << g_q;
                        port_data_rd_o <= '0;
                        port_ex_fail_o <= PORTS'(1) << g_q;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: table-driven and directed checks of bus_master_arb with PORTS = 4.
module tb_bus_master_arb;
    import bus_master_arb_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] start, wr_m, exl;
    logic [29:0] base;
    word_t wd, rdata;
    logic [3:0] be;
    logic waitreq;
    logic [1:0] resp;
    ptr_t [3:0] p_addr;
    word_t [3:0] p_wd;
    logic [3:0][3:0] p_be;
    logic [3:0] port_ready, port_ex_fail;
    word_t port_data_rd, avl_address, avl_writedata;
    logic avl_read, avl_write, avl_lock;
    logic [3:0] avl_byteenable;
    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p_addr[i] = base + 30'(i);
            p_wd[i]   = wd;
            p_be[i]   = be;
        end
    end

    bus_master_arb #(.PORTS(4), .TIMEOUT(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .port_start_i      (start),
        .port_write_i      (wr_m),
        .port_addr_i       (p_addr),
        .port_data_wr_i    (p_wd),
        .port_data_be_i    (p_be),
        .port_ex_lock_i    (exl),
        .port_ready_o      (port_ready),
        .port_data_rd_o    (port_data_rd),
        .port_ex_fail_o    (port_ex_fail),
        .avl_address_o     (avl_address),
        .avl_read_o        (avl_read),
        .avl_write_o       (avl_write),
        .avl_lock_o        (avl_lock),
        .avl_writedata_o   (avl_writedata),
        .avl_byteenable_o  (avl_byteenable),
        .avl_readdata_i    (rdata),
        .avl_waitrequest_i (waitreq),
        .avl_response_i    (resp)
    );

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  wr;
        logic [29:0] base;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        wt;
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [3:0]  e_rdy;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_adr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic [31:0] e_drd;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ready(output logic [3:0] r);
        r = '0;
        for (int n = 0; n < 16 && r == 4'h0; n++) begin
            step();
            r = port_ready;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        int n;
        v[0]  = '{4'h1, 4'h0, 30'h10,  32'h0,        4'hF, 1'b0, 32'h0,        2'b00, 4'h0, 1'b1, 1'b0, 32'h40,  32'h0,        4'hF, 32'h0};
        v[1]  = '{4'h0, 4'h0, 30'h10,  32'h0,        4'hF, 1'b0, 32'hCAFEBABE, 2'b00, 4'h1, 1'b0, 1'b0, 32'h40,  32'h0,        4'hF, 32'hCAFEBABE};
        v[2]  = '{4'h0, 4'h0, 30'h10,  32'h0,        4'hF, 1'b0, 32'h0,        2'b00, 4'h0, 1'b0, 1'b0, 32'h40,  32'h0,        4'hF, 32'hCAFEBABE};
        v[3]  = '{4'h2, 4'h2, 30'h20,  32'h12345678, 4'h3, 1'b1, 32'h0,        2'b00, 4'h0, 1'b0, 1'b1, 32'h84,  32'h12345678, 4'h3, 32'hCAFEBABE};
        v[4]  = '{4'h0, 4'h2, 30'h20,  32'h12345678, 4'h3, 1'b1, 32'h0,        2'b00, 4'h0, 1'b0, 1'b1, 32'h84,  32'h12345678, 4'h3, 32'hCAFEBABE};
        v[5]  = v[4];
        v[6]  = v[4];
        v[7]  = '{4'h0, 4'h2, 30'h20,  32'h12345678, 4'h3, 1'b0, 32'h0,        2'b00, 4'h2, 1'b0, 1'b0, 32'h84,  32'h12345678, 4'h3, 32'h0};
        v[8]  = '{4'h0, 4'h0, 30'h20,  32'h12345678, 4'h3, 1'b0, 32'h0,        2'b00, 4'h0, 1'b0, 1'b0, 32'h84,  32'h12345678, 4'h3, 32'h0};
        v[9]  = '{4'h3, 4'h0, 30'h100, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        2'b00, 4'h0, 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, 4'hF, 32'h0};
        v[10] = '{4'h0, 4'h0, 30'h100, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h11111111, 2'b10, 4'h1, 1'b0, 1'b0, 32'h400, 32'hA5A5A5A5, 4'hF, 32'h11111111};
        v[11] = '{4'h0, 4'h0, 30'h100, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0,        2'b00, 4'h0, 1'b1, 1'b0, 32'h404, 32'hA5A5A5A5, 4'hF, 32'h11111111};
        v[12] = '{4'h0, 4'h0, 30'h100, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h22222222, 2'b00, 4'h2, 1'b0, 1'b0, 32'h404, 32'hA5A5A5A5, 4'hF, 32'h22222222};
        v[13] = '{4'h0, 4'h0, 30'h100, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        2'b00, 4'h0, 1'b0, 1'b0, 32'h404, 32'hA5A5A5A5, 4'hF, 32'h22222222};

        start = '0; wr_m = '0; exl = '0; base = '0; wd = '0; be = '0;
        rdata = '0; waitreq = 1'b0; resp = 2'b00;
        rst = 1'b1;
        step();
        chk("rst.ready", 32'(port_ready), 32'h0);
        chk("rst.exfail", 32'(port_ex_fail), 32'h0);
        chk("rst.data_rd", port_data_rd, 32'h0);
        chk("rst.cmd", 32'({avl_read, avl_write, avl_lock}), 32'h0);
        chk("rst.addr", avl_address, 32'h0);
        chk("rst.wdata", avl_writedata, 32'h0);
        chk("rst.be", 32'(avl_byteenable), 32'h0);
        rst = 1'b0;

        // single read, stalled write, pointer wrap and back-to-back grants
        for (int i = 0; i < 14; i++) begin
            start = v[i].st; wr_m = v[i].wr; base = v[i].base; wd = v[i].wd; be = v[i].be;
            waitreq = v[i].wt; rdata = v[i].rd; resp = v[i].rsp;
            step();
            chk($sformatf("v%0d.ready", i), 32'(port_ready), 32'(v[i].e_rdy));
            chk($sformatf("v%0d.exfail", i), 32'(port_ex_fail), 32'h0);
            chk($sformatf("v%0d.read", i), 32'(avl_read), 32'(v[i].e_rd));
            chk($sformatf("v%0d.write", i), 32'(avl_write), 32'(v[i].e_wr));
            chk($sformatf("v%0d.addr", i), avl_address, v[i].e_adr);
            chk($sformatf("v%0d.wdata", i), avl_writedata, v[i].e_wd);
            chk($sformatf("v%0d.be", i), 32'(avl_byteenable), 32'(v[i].e_be));
            chk($sformatf("v%0d.data_rd", i), port_data_rd, v[i].e_drd);
        end
        start = '0;

        // fairness: all four ports start together, three rounds
        do_reset();
        waitreq = 1'b0; wr_m = '0; base = 30'h200;
        for (int k = 0; k < 3; k++) begin
            start = 4'hF;
            step();
            start = '0;
            for (int p = 0; p < 4; p++) begin
                wait_ready(r);
                chk($sformatf("fair.r%0d.p%0d", k, p), 32'(r), 32'(4'h1 << p));
            end
        end

        // exclusive lock held by port 1 across a read and a write
        do_reset();
        base = 30'h40; wd = 32'hDEADBEEF; be = 4'hF;
        exl = 4'h2; start = 4'h2; wr_m = 4'h0;
        step();
        chk("lock.a.read", 32'(avl_read), 32'h1);
        chk("lock.a.lock", 32'(avl_lock), 32'h1);
        chk("lock.a.addr", avl_address, 32'h104);
        start = 4'h1; waitreq = 1'b0; rdata = 32'h0BADF00D; resp = 2'b00;
        step();
        chk("lock.b.ready", 32'(port_ready), 32'h2);
        chk("lock.b.data", port_data_rd, 32'h0BADF00D);
        start = '0;
        step();
        chk("lock.c.blocked", 32'({avl_read, avl_write}), 32'h0);
        chk("lock.c.lock", 32'(avl_lock), 32'h1);
        start = 4'h2; wr_m = 4'h2;
        step();
        chk("lock.d.write", 32'(avl_write), 32'h1);
        chk("lock.d.lock", 32'(avl_lock), 32'h1);
        chk("lock.d.addr", avl_address, 32'h104);
        start = '0; wr_m = '0; resp = 2'b10;
        step();
        chk("lock.e.ready", 32'(port_ready), 32'h2);
        chk("lock.e.exfail", 32'(port_ex_fail), 32'h2);
        exl = '0; resp = 2'b00;
        step();
        chk("lock.f.read", 32'(avl_read), 32'h1);
        chk("lock.f.lock", 32'(avl_lock), 32'h0);
        chk("lock.f.addr", avl_address, 32'h100);
        resp = 2'b10;
        step();
        chk("lock.g.ready", 32'(port_ready), 32'h1);
        chk("lock.g.exfail", 32'(port_ex_fail), 32'h0);
        resp = 2'b00;
        step();

        // reset during a stalled read, with another port pending
        start = 4'h4; waitreq = 1'b1;
        step();
        chk("rstmid.read", 32'(avl_read), 32'h1);
        start = 4'h8;
        step();
        start = '0;
        #2 rst = 1'b1;
        #1 chk("rstmid.async", 32'(avl_read), 32'h0);
        step();
        rst = 1'b0; waitreq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rstmid.noready%0d", k), 32'(port_ready | {3'b0, avl_read}), 32'h0);
        end
        base = 30'h300; rdata = 32'h77777777; start = 4'h1;
        step();
        chk("rstmid.new.read", 32'(avl_read), 32'h1);
        chk("rstmid.new.addr", avl_address, 32'hC00);
        start = '0;
        step();
        chk("rstmid.new.ready", 32'(port_ready), 32'h1);
        chk("rstmid.new.data", port_data_rd, 32'h77777777);
        step();

`ifdef CONFIG_BUS_MASTER_TIMEOUT_EN
        // stuck waitrequest: dropped after TIMEOUT (8) command cycles
        start = 4'h1; waitreq = 1'b1; rdata = 32'h55555555;
        step();
        start = '0;
        n = 0;
        for (int k = 0; k < 20 && port_ready == 4'h0; k++) begin
            if (avl_read) n++;
            step();
        end
        chk("timeout.cycles", 32'(n), 32'd8);
        chk("timeout.ready", 32'(port_ready), 32'h1);
        chk("timeout.exfail", 32'(port_ex_fail), 32'h1);
        chk("timeout.data", port_data_rd, 32'h0);
        chk("timeout.read", 32'(avl_read), 32'h0);
        waitreq = 1'b0;
        step();
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
